// File: rtl/int_dispatch_pkg.sv
// Shared definitions for the interrupt dispatcher: source indices, vector base,
// dispatch FSM encoding and the vector computation.
package int_dispatch_pkg;

  localparam int unsigned NumIrq = 5;
  localparam logic [7:0]  VecBase = 8'h40;

  localparam int unsigned IrqVbl    = 0;
  localparam int unsigned IrqStat   = 1;
  localparam int unsigned IrqTimer  = 2;
  localparam int unsigned IrqSerial = 3;
  localparam int unsigned IrqJoypad = 4;

  typedef enum logic [2:0] {
    StIdle,
    StNop1,
    StNop2,
    StPushHi,
    StPushLo,
    StJump
  } disp_state_e;

  // Source n jumps to base + 8n.
  function automatic logic [7:0] irq_vector(input logic [7:0] base, input logic [2:0] idx);
    return base + {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/int_dispatch_if.sv
// CPU data-bus view of the IE register (FFFF): write value, strobes and read data.
interface int_dispatch_if;
  logic [7:0] d_in;
  logic       nffff_wr;
  logic       nffff_rd;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (
    output d_in, nffff_wr, nffff_rd,
    input  d_out, d_oe
  );

  modport slave (
    input  d_in, nffff_wr, nffff_rd,
    output d_out, d_oe
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module irq_prio_enc
  import int_dispatch_pkg::*;
(
  input  logic [NumIrq-1:0] req_i,
  output logic              valid_o,
  output logic [2:0]        idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NumIrq - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/int_dispatch.sv
// CPU-side interrupt scheduler: IE/IME registers, fixed-priority arbitration,
// 5-M-cycle dispatch sequence and HALT entry/wake with the HALT-bug pulse.
module int_dispatch
  import int_dispatch_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = NumIrq,
  parameter logic [7:0]  VEC_BASE = VecBase
) (
  input  logic       boga1mhz,
  input  logic       nreset2,

  input  logic       cpu_irq0_trig,
  input  logic       cpu_irq1_trig,
  input  logic       cpu_irq2_trig,
  input  logic       cpu_irq3_trig,
  input  logic       cpu_irq4_trig,

  int_dispatch_if.slave ie_bus,

  input  logic       instr_boundary,
  input  logic       ime_set,
  input  logic       ime_clr,
  input  logic       reti,
  input  logic       halt_req,

  output logic       cpu_irq0_ack,
  output logic       cpu_irq1_ack,
  output logic       cpu_irq2_ack,
  output logic       cpu_irq3_ack,
  output logic       cpu_irq4_ack,

  output logic       push_hi,
  output logic       push_lo,
  output logic       pc_load,
  output logic [7:0] vector,
  output logic       dispatch_busy,
  output logic       halted,
  output logic       halt_bug,
  output logic       ime
);

  disp_state_e        state_q;
  logic [7:0]         ie_q;
  logic               ime_q;
  logic               ime_pend_q;
  logic               halted_q;
  logic               halt_bug_q;
  logic               push_hi_q;
  logic               push_lo_q;
  logic               pc_load_q;
  logic               busy_q;
  logic [7:0]         vector_q;
  logic [NUM_IRQ-1:0] ack_q;

  logic [NUM_IRQ-1:0] trig;
  logic [NUM_IRQ-1:0] pend;
  logic               any_pend;
  logic               sel_valid;
  logic [2:0]         sel_idx;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic               start_dispatch;

  assign trig[IrqVbl]    = cpu_irq0_trig;
  assign trig[IrqStat]   = cpu_irq1_trig;
  assign trig[IrqTimer]  = cpu_irq2_trig;
  assign trig[IrqSerial] = cpu_irq3_trig;
  assign trig[IrqJoypad] = cpu_irq4_trig;

  // IE[7:5] are storage only; they never reach arbitration.
  assign pend     = trig & ie_q[NUM_IRQ-1:0];
  assign any_pend = |pend;

  irq_prio_enc u_prio_enc (
    .req_i   (pend),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      sel_onehot[i] = sel_valid && (int'(sel_idx) == i);
    end
  end

  assign start_dispatch = ime_q && any_pend &&
                          (((state_q == StIdle) && instr_boundary) || halted_q);

  always_ff @(posedge boga1mhz or negedge nreset2) begin
    if (!nreset2) begin
      state_q    <= StIdle;
      ie_q       <= 8'h00;
      ime_q      <= 1'b0;
      ime_pend_q <= 1'b0;
      halted_q   <= 1'b0;
      halt_bug_q <= 1'b0;
      push_hi_q  <= 1'b0;
      push_lo_q  <= 1'b0;
      pc_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      vector_q   <= 8'h00;
      ack_q      <= '0;
    end else begin
      push_hi_q  <= 1'b0;
      push_lo_q  <= 1'b0;
      pc_load_q  <= 1'b0;
      halt_bug_q <= 1'b0;
      ack_q      <= '0;

      if (!ie_bus.nffff_wr) begin
        ie_q <= ie_bus.d_in;
      end

      // EI takes effect one instruction late; a fresh EI on the promoting
      // boundary re-arms the pending flag.
      if (ime_pend_q && instr_boundary) begin
        ime_q      <= 1'b1;
        ime_pend_q <= ime_set;
      end else if (ime_set) begin
        ime_pend_q <= 1'b1;
      end
      if (reti) begin
        ime_q <= 1'b1;
      end
      if (ime_clr) begin
        ime_q      <= 1'b0;
        ime_pend_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start_dispatch) begin
            state_q  <= StNop1;
            ime_q    <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b1;
          end else if (halted_q) begin
            if (any_pend) begin
              halted_q <= 1'b0;
            end
          end else if (halt_req) begin
            if (ime_q || !any_pend) begin
              halted_q <= 1'b1;
            end else begin
              halt_bug_q <= 1'b1;
            end
          end
        end
        StNop1: state_q <= StNop2;
        StNop2: begin
          state_q   <= StPushHi;
          push_hi_q <= 1'b1;
        end
        StPushHi: begin
          // Winner is chosen here, so late higher-priority flags still win.
          state_q   <= StPushLo;
          push_lo_q <= 1'b1;
          vector_q  <= sel_valid ? irq_vector(VEC_BASE, sel_idx) : 8'h00;
          ack_q     <= sel_onehot;
        end
        StPushLo: begin
          state_q   <= StJump;
          pc_load_q <= 1'b1;
        end
        StJump: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ie_bus.d_out = ie_q;
  assign ie_bus.d_oe  = !ie_bus.nffff_rd;

  assign cpu_irq0_ack = ack_q[IrqVbl];
  assign cpu_irq1_ack = ack_q[IrqStat];
  assign cpu_irq2_ack = ack_q[IrqTimer];
  assign cpu_irq3_ack = ack_q[IrqSerial];
  assign cpu_irq4_ack = ack_q[IrqJoypad];

  assign push_hi       = push_hi_q;
  assign push_lo       = push_lo_q;
  assign pc_load       = pc_load_q;
  assign vector        = vector_q;
  assign dispatch_busy = busy_q;
  assign halted        = halted_q;
  assign halt_bug      = halt_bug_q;
  assign ime           = ime_q;

endmodule

// File: tb/tb_int_dispatch.sv
// Scoreboard bench for int_dispatch: stimulus queues expected strobe events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_int_dispatch;

  logic       clk;
  logic       nreset2;
  logic [4:0] trig;
  logic       instr_boundary, ime_set, ime_clr, reti, halt_req;
  logic [4:0] ack;
  logic       push_hi, push_lo, pc_load, dispatch_busy, halted, halt_bug, ime;
  logic [7:0] vector;
  int         cyc;
  int         checks;
  int         failures;

  typedef struct {
    logic [3:0] fl;   // {push_hi, push_lo, pc_load, halt_bug}
    logic [4:0] ack;
    logic [7:0] vec;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];

  int_dispatch_if bus ();

  int_dispatch dut (
    .boga1mhz       (clk),
    .nreset2        (nreset2),
    .cpu_irq0_trig  (trig[0]),
    .cpu_irq1_trig  (trig[1]),
    .cpu_irq2_trig  (trig[2]),
    .cpu_irq3_trig  (trig[3]),
    .cpu_irq4_trig  (trig[4]),
    .ie_bus         (bus),
    .instr_boundary (instr_boundary),
    .ime_set        (ime_set),
    .ime_clr        (ime_clr),
    .reti           (reti),
    .halt_req       (halt_req),
    .cpu_irq0_ack   (ack[0]),
    .cpu_irq1_ack   (ack[1]),
    .cpu_irq2_ack   (ack[2]),
    .cpu_irq3_ack   (ack[3]),
    .cpu_irq4_ack   (ack[4]),
    .push_hi        (push_hi),
    .push_lo        (push_lo),
    .pc_load        (pc_load),
    .vector         (vector),
    .dispatch_busy  (dispatch_busy),
    .halted         (halted),
    .halt_bug       (halt_bug),
    .ime            (ime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle with any strobe/ack must match the next queued event.
  always @(negedge clk) begin
    logic [3:0] fl;
    ev_t        e;
    fl = {push_hi, push_lo, pc_load, halt_bug};
    if (fl != 4'b0 || ack != 5'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%b/%b required=none (cyc %0d)", fl, ack, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ev_flags", 32'(fl), 32'(e.fl));
        check("ev_ack", 32'(ack), 32'(e.ack));
        if (e.fl[2] || e.fl[1]) check("ev_vector", 32'(vector), 32'(e.vec));
        check("ev_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_ie(input logic [7:0] v);
    bus.d_in     = v;
    bus.nffff_wr = 1'b0;
    step();
    bus.nffff_wr = 1'b1;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    step();
    reti = 1'b0;
  endtask

  task automatic boundary();
    instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0;
  endtask

  // s = cycle in which the start condition is sampled ("clock 0").
  task automatic exp_dispatch(input int s, input logic [4:0] a, input logic [7:0] v);
    exp_q.push_back('{fl: 4'b1000, ack: 5'b0, vec: 8'h00, cyc: s + 3});
    exp_q.push_back('{fl: 4'b0100, ack: a,    vec: v,     cyc: s + 4});
    exp_q.push_back('{fl: 4'b0010, ack: 5'b0, vec: v,     cyc: s + 5});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    nreset2 = 1'b0;
    trig = '0;
    instr_boundary = 0; ime_set = 0; ime_clr = 0; reti = 0; halt_req = 0;
    bus.d_in = 8'h00; bus.nffff_wr = 1'b1; bus.nffff_rd = 1'b0;
    repeat (2) step();
    nreset2 = 1'b1;
    step();

    // Reset state
    check("rst_ie", 32'(bus.d_out), 32'h00);
    check("rst_doe_rd", 32'(bus.d_oe), 32'h1);
    check("rst_ime", 32'(ime), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_vector", 32'(vector), 32'h00);
    check("rst_busy", 32'(dispatch_busy), 32'h0);
    bus.nffff_rd = 1'b1;
    #1 check("doe_idle", 32'(bus.d_oe), 32'h0);
    bus.nffff_rd = 1'b0;

    // Basic vblank dispatch
    wr_ie(8'h01);
    check("ie_rd_01", 32'(bus.d_out), 32'h01);
    pulse_reti();
    check("reti_ime", 32'(ime), 32'h1);
    trig = 5'b00001;
    exp_dispatch(cyc, 5'b00001, 8'h40);
    boundary();
    check("busy_nop1", 32'(dispatch_busy), 32'h1);
    check("ime_cleared_on_start", 32'(ime), 32'h0);
    repeat (5) step();
    check("busy_done", 32'(dispatch_busy), 32'h0);
    trig = '0;

    // IE[7:5] never arbitrated; clr beats set
    wr_ie(8'hE0);
    check("ie_rd_e0", 32'(bus.d_out), 32'hE0);
    pulse_reti();
    trig = 5'h1F;
    boundary();
    check("ie_hi_no_dispatch", 32'(dispatch_busy), 32'h0);
    ime_clr = 1'b1; ime_set = 1'b1;
    step();
    ime_clr = 1'b0; ime_set = 1'b0;
    check("clr_wins", 32'(ime), 32'h0);
    boundary();
    boundary();
    check("clr_cleared_pend", 32'(ime), 32'h0);
    trig = '0;

    // Late higher-priority flag wins; lower one stays pending
    wr_ie(8'h1F);
    pulse_reti();
    trig = 5'b10000;
    exp_dispatch(cyc, 5'b00100, 8'h50);
    boundary();
    trig = 5'b10100;
    repeat (5) step();
    trig = 5'b10000;
    pulse_reti();
    exp_dispatch(cyc, 5'b10000, 8'h60);
    boundary();
    repeat (5) step();
    trig = '0;

    // IE cleared during NOP2: null vector, no ack
    wr_ie(8'h01);
    pulse_reti();
    trig = 5'b00001;
    exp_dispatch(cyc, 5'b00000, 8'h00);
    boundary();
    step();
    wr_ie(8'h00);
    repeat (3) step();
    check("null_ime", 32'(ime), 32'h0);
    check("null_busy", 32'(dispatch_busy), 32'h0);
    trig = '0;

    // EI delay: first boundary promotes, second dispatches
    wr_ie(8'h01);
    trig = 5'b00001;
    ime_set = 1'b1;
    step();
    ime_set = 1'b0;
    check("ei_not_yet", 32'(ime), 32'h0);
    boundary();
    check("ei_no_dispatch_first", 32'(dispatch_busy), 32'h0);
    check("ei_promoted", 32'(ime), 32'h1);
    exp_dispatch(cyc, 5'b00001, 8'h40);
    boundary();
    repeat (5) step();
    trig = '0;

    // HALT bug, HALT entry, wake without IME
    wr_ie(8'h04);
    trig = 5'b00100;
    exp_q.push_back('{fl: 4'b0001, ack: 5'b0, vec: 8'h00, cyc: cyc + 1});
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("haltbug_not_halted", 32'(halted), 32'h0);
    step();
    trig = 5'b00000;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_entered", 32'(halted), 32'h1);
    step();
    check("halt_held", 32'(halted), 32'h1);
    trig = 5'b00100;
    step();
    check("wake_cleared", 32'(halted), 32'h0);
    step();
    check("wake_no_dispatch", 32'(dispatch_busy), 32'h0);
    trig = '0;

    // HALT with IME: wake edge starts dispatch
    pulse_reti();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_ime_entered", 32'(halted), 32'h1);
    trig = 5'b00100;
    exp_dispatch(cyc, 5'b00100, 8'h50);
    step();
    check("halt_wake_dispatch", 32'(dispatch_busy), 32'h1);
    check("halt_wake_unhalted", 32'(halted), 32'h0);
    repeat (5) step();
    trig = '0;

    // Async reset during PUSH_HI
    wr_ie(8'h01);
    pulse_reti();
    trig = 5'b00001;
    exp_q.push_back('{fl: 4'b1000, ack: 5'b0, vec: 8'h00, cyc: cyc + 3});
    boundary();
    repeat (2) step();
    @(negedge clk);
    #1 nreset2 = 1'b0;
    #1;
    check("arst_push_hi", 32'(push_hi), 32'h0);
    check("arst_busy", 32'(dispatch_busy), 32'h0);
    check("arst_vector", 32'(vector), 32'h00);
    check("arst_ie", 32'(bus.d_out), 32'h00);
    check("arst_ime", 32'(ime), 32'h0);
    repeat (2) step();
    nreset2 = 1'b1;
    repeat (8) step();
    trig = '0;

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
